// File: rtl/sinc3_decimator_pkg.sv
// Shared constants and width helpers for the sinc^3 filter and its decimator.
package sinc3_decimator_pkg;

  localparam int unsigned DEFAULT_OSR       = 16;
  localparam int unsigned DEFAULT_OUT_WIDTH = 16;

  // Full-precision sinc^3 output width for a given oversampling ratio.
  function automatic int unsigned in_width(input int unsigned osr);
    return 3 * $clog2(osr) + 1;
  endfunction

  // Bits discarded by rounding when narrowing; zero when the output is wider.
  function automatic int unsigned round_shift(input int unsigned in_w,
                                              input int unsigned out_w);
    return (in_w > out_w) ? in_w - out_w : 0;
  endfunction

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/sinc3_dec_fifo.sv
// Two-entry first-in first-out buffer; head register drives the read port directly.
module sinc3_dec_fifo
  import sinc3_decimator_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  fifo_state_e      state, state_next;
  logic [WIDTH-1:0] head, tail;
  logic             do_pop, do_push;

  // A pop frees the slot a simultaneous push needs, so full+pop still accepts.
  always_comb begin
    do_pop  = pop && (state != FIFO_EMPTY);
    do_push = push && ((state != FIFO_FULL) || do_pop);
  end

  always_comb begin
    state_next = state;
    case (state)
      FIFO_EMPTY: if (do_push) state_next = FIFO_ONE;
      FIFO_ONE: begin
        if (do_pop && !do_push)      state_next = FIFO_EMPTY;
        else if (do_push && !do_pop) state_next = FIFO_FULL;
      end
      FIFO_FULL:  if (do_pop && !do_push) state_next = FIFO_ONE;
      default:    state_next = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FIFO_EMPTY;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (do_pop && do_push) begin
      if (state == FIFO_FULL) begin
        head <= tail;
        tail <= wr_data;
      end else begin
        head <= wr_data;
      end
    end else if (do_pop) begin
      head <= tail;
    end else if (do_push) begin
      if (state == FIFO_EMPTY) head <= wr_data;
      else                     tail <= wr_data;
    end
  end

  always_comb begin
    full    = (state == FIFO_FULL);
    empty   = (state == FIFO_EMPTY);
    rd_data = head;
  end

endmodule

// File: rtl/sinc3_decimator.sv
// Decimates a free-running sinc^3 filter output by OSR, rescales to OUT_WIDTH and
// buffers results in a 2-entry FIFO with a sticky overflow flag.
module sinc3_decimator
  import sinc3_decimator_pkg::*;
#(
  parameter  int unsigned OSR       = DEFAULT_OSR,
  parameter  int unsigned OUT_WIDTH = DEFAULT_OUT_WIDTH,
  parameter  int unsigned SETTLE    = 3,
  localparam int unsigned IN_W      = in_width(OSR)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [IN_W-1:0]      inData,
  output logic signed [OUT_WIDTH-1:0] outData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        overflow
);

  localparam int unsigned PH_W  = $clog2(OSR);
  localparam int unsigned SET_W = $clog2(SETTLE + 2);

  logic [PH_W-1:0]             phase;
  logic [SET_W-1:0]            settle;
  logic                        capture, settled;
  logic                        cap_valid, scl_valid;
  logic signed [IN_W-1:0]      cap_data;
  logic signed [OUT_WIDTH-1:0] scaled, scl_data;
  logic                        fifo_full, fifo_empty, pop;
  logic [OUT_WIDTH-1:0]        fifo_rd;

  always_comb begin
    capture = en && (phase == PH_W'(OSR - 1));
    settled = (settle == SET_W'(SETTLE));
  end

  generate
    if (OUT_WIDTH >= IN_W) begin : g_widen
      always_comb scaled = OUT_WIDTH'(cap_data) <<< (OUT_WIDTH - IN_W);
    end else begin : g_narrow
      localparam int unsigned SHIFT = round_shift(IN_W, OUT_WIDTH);
      localparam logic signed [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
      logic signed [IN_W:0] sum, shifted;
      // One guard bit keeps the rounding add from wrapping at full scale.
      always_comb begin
        sum     = {cap_data[IN_W-1], cap_data} + RND;
        shifted = sum >>> SHIFT;
        if ((&shifted[IN_W:OUT_WIDTH-1]) || ~(|shifted[IN_W:OUT_WIDTH-1]))
          scaled = shifted[OUT_WIDTH-1:0];
        else if (shifted[IN_W])
          scaled = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
          scaled = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      settle    <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      scl_valid <= 1'b0;
      scl_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (en) phase <= phase + 1'b1;
      if (capture) begin
        cap_data <= inData;
        if (!settled) settle <= settle + 1'b1;
      end
      cap_valid <= capture && settled;
      scl_valid <= cap_valid;
      if (cap_valid) scl_data <= scaled;
      if (scl_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    outValid = !fifo_empty;
    pop      = outValid && outReady;
    outData  = fifo_rd;
  end

  sinc3_dec_fifo #(
    .WIDTH(OUT_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (scl_valid),
    .wr_data(scl_data),
    .full   (fifo_full),
    .pop    (pop),
    .empty  (fifo_empty),
    .rd_data(fifo_rd)
  );

endmodule

// File: tb/tb_sinc3_decimator.sv
// Directed bench for sinc3_decimator: a 16-bit and an 8-bit instance share stimulus.
module tb_sinc3_decimator;
  import sinc3_decimator_pkg::*;

  localparam int unsigned IN_W = in_width(16);

  logic                   clk, rst, en, out_ready;
  logic signed [IN_W-1:0] in_data;
  logic signed [15:0]     out16;
  logic signed [7:0]      out8;
  logic                   valid16, valid8, ovf16, ovf8;
  int                     nvec = 0;
  int                     nerr = 0;

  sinc3_decimator #(.OSR(16), .OUT_WIDTH(16), .SETTLE(3)) dut (
    .clk(clk), .rst(rst), .en(en), .inData(in_data),
    .outData(out16), .outValid(valid16), .outReady(out_ready), .overflow(ovf16)
  );

  sinc3_decimator #(.OSR(16), .OUT_WIDTH(8), .SETTLE(3)) dut8 (
    .clk(clk), .rst(rst), .en(en), .inData(in_data),
    .outData(out8), .outValid(valid8), .outReady(out_ready), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // n en pulses, each followed by two idle cycles.
  task automatic pulses3(input int n);
    repeat (n) begin
      en = 1'b1;
      tick(1);
      en = 1'b0;
      tick(2);
    end
  endtask

  // Capture pulse with en idle afterwards: valid two edges later, not one.
  task automatic pulse_out3(input string tag, input int exp);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(1);
    chk({tag, "_early"}, valid16, 0);
    tick(1);
    chk({tag, "_valid"}, valid16, 1);
    chk({tag, "_data"}, out16, exp);
  endtask

  int vals[6]  = '{2048, -2048, 4095, -4096, 15, 16};
  int exp8[6]  = '{64, -64, 127, -128, 0, 1};
  int exp16[6] = '{16384, -16384, 32760, -32768, 120, 128};

  initial begin
    rst = 1'b1; en = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(2);
    chk("rst_valid", valid16, 0);
    chk("rst_data", out16, 0);
    chk("rst_ovf", ovf16, 0);
    chk("rst_valid8", valid8, 0);

    // Continuous en, constant input.
    rst = 1'b0; en = 1'b1; in_data = 100; out_ready = 1'b1;
    tick(65);
    chk("cont_early", valid16, 0);
    tick(1);
    chk("cont_first_valid", valid16, 1);
    chk("cont_first_data", out16, 800);
    chk("cont_first_valid8", valid8, 1);
    chk("cont_first_data8", out8, 3);
    for (int k = 0; k < 3; k++) begin
      tick(15);
      chk("cont_gap", valid16, 0);
      tick(1);
      chk("cont_next_valid", valid16, 1);
      chk("cont_next_data", out16, 800);
    end
    chk("cont_ovf", ovf16, 0);

    // en every third cycle: same sequence, stretched.
    en = 1'b0;
    do_reset();
    pulses3(63);
    pulse_out3("slow_first", 800);
    pulses3(15);
    pulse_out3("slow_second", 800);

    // Rounding and saturation sweep.
    en = 1'b0;
    do_reset();
    en = 1'b1;
    tick(48);
    in_data = IN_W'(vals[0]);
    tick(16);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("sweep_early8", valid8, 0);
      tick(1);
      chk("sweep_valid8", valid8, 1);
      chk("sweep_data8", out8, exp8[k]);
      chk("sweep_data16", out16, exp16[k]);
      if (k < 5) begin
        in_data = IN_W'(vals[k+1]);
        tick(14);
      end
    end

    // Back-pressure: two held, third dropped, overflow sticky.
    do_reset();
    out_ready = 1'b0; in_data = 1;
    tick(64);
    in_data = 2;
    tick(2);
    chk("bp_first_valid", valid16, 1);
    chk("bp_first_data", out16, 8);
    tick(14);
    in_data = 3;
    tick(16);
    in_data = 4;
    tick(1);
    chk("bp_ovf_before", ovf16, 0);
    tick(1);
    chk("bp_ovf_set", ovf16, 1);
    chk("bp_head_kept", out16, 8);
    tick(10);
    chk("bp_ovf_sticky", ovf16, 1);
    chk("bp_hold_valid", valid16, 1);
    chk("bp_hold_data", out16, 8);
    out_ready = 1'b1;
    tick(1);
    chk("bp_second_valid", valid16, 1);
    chk("bp_second_data", out16, 16);
    tick(1);
    chk("bp_drained", valid16, 0);
    chk("bp_ovf_after_drain", ovf16, 1);

    // Full FIFO with pop on the push cycle.
    do_reset();
    out_ready = 1'b0; in_data = 5;
    tick(64);
    in_data = 6;
    tick(16);
    in_data = 7;
    tick(17);
    out_ready = 1'b1;
    tick(1);
    chk("fp_valid", valid16, 1);
    chk("fp_head", out16, 48);
    chk("fp_ovf", ovf16, 0);
    tick(1);
    chk("fp_next", out16, 56);
    chk("fp_next_valid", valid16, 1);
    tick(1);
    chk("fp_drained", valid16, 0);
    chk("fp_ovf_end", ovf16, 0);

    // Reset mid-stream with two samples queued and overflow set.
    do_reset();
    out_ready = 1'b0; in_data = 9;
    tick(98);
    chk("mr_pre_valid", valid16, 1);
    chk("mr_pre_ovf", ovf16, 1);
    rst = 1'b1;
    tick(1);
    chk("mr_valid", valid16, 0);
    chk("mr_ovf", ovf16, 0);
    chk("mr_data", out16, 0);
    rst = 1'b0; in_data = 10;
    tick(65);
    chk("mr_early", valid16, 0);
    tick(1);
    chk("mr_first_valid", valid16, 1);
    chk("mr_first_data", out16, 80);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
